// File: rtl/rob_if.sv
// ---------------------------------------------------------------------------
// rob_pkg / rob_if
//
// rob_pkg holds the retire-slot payload type shared by the reorder buffer and
// its writeback consumer.
//
// rob_if groups every non-clock signal of the reorder buffer:
//   allocate : alloc_req, alloc_dest_reg, alloc_dest_reg_valid  (to ROB)
//              alloc_ready, alloc_tag                           (from ROB)
//   complete : cpl_valid[2], cpl_tag[2], cpl_result_lo/hi[2]    (to ROB)
//   control  : flush, consume, consume_count                    (to ROB)
//   retire   : slot_data[RETIRE_COUNT], slot_valid              (from ROB)
//   status   : empty, occupancy                                 (from ROB)
// The master modport belongs to the pipeline/writeback side, and the slave
// modport belongs to the ROB.
// ---------------------------------------------------------------------------
package rob_pkg;

  typedef struct packed {
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
  } rob_entry_t;

endpackage

interface rob_if #(
  parameter int DEPTH        = 16,
  parameter int RETIRE_COUNT = 4,
  parameter int COUNT_WIDTH  = $clog2(RETIRE_COUNT),
  parameter int TAG_WIDTH    = $clog2(DEPTH)
);
  import rob_pkg::*;

  // allocate
  logic                   alloc_req;
  logic [4:0]             alloc_dest_reg;
  logic                   alloc_dest_reg_valid;
  logic                   alloc_ready;
  logic [TAG_WIDTH-1:0]   alloc_tag;

  // complete (two independent ports)
  logic [1:0]             cpl_valid;
  logic [TAG_WIDTH-1:0]   cpl_tag       [2];
  logic [31:0]            cpl_result_lo [2];
  logic [31:0]            cpl_result_hi [2];

  // control
  logic                   flush;
  logic                   consume;
  logic [COUNT_WIDTH-1:0] consume_count;

  // retire window and status
  rob_entry_t             slot_data [RETIRE_COUNT];
  logic [RETIRE_COUNT-1:0] slot_valid;
  logic                   empty;
  logic [TAG_WIDTH:0]     occupancy;

  modport master (
    output alloc_req, alloc_dest_reg, alloc_dest_reg_valid,
    output cpl_valid, cpl_tag, cpl_result_lo, cpl_result_hi,
    output flush, consume, consume_count,
    input  alloc_ready, alloc_tag, slot_data, slot_valid, empty, occupancy
  );

  modport slave (
    input  alloc_req, alloc_dest_reg, alloc_dest_reg_valid,
    input  cpl_valid, cpl_tag, cpl_result_lo, cpl_result_hi,
    input  flush, consume, consume_count,
    output alloc_ready, alloc_tag, slot_data, slot_valid, empty, occupancy
  );

endinterface

// File: rtl/rob.sv
// ---------------------------------------------------------------------------
// rob - in-order reorder buffer feeding the writeback/retire stage.
//
// Entries are allocated one per cycle at the tail in program order. Results
// arrive out of order on two completion ports that are addressed by tag.
// The RETIRE_COUNT entries starting at head are presented as a retire window.
// slot_valid is a contiguous prefix of entries that are both allocated and
// completed. Writeback pops 1..RETIRE_COUNT entries using consume and
// consume_count. The pop count is clamped to the valid prefix.
//
// Ports:
//   clock    : single clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset (same end state as flush)
//   bus      : rob_if.slave, which carries the allocate, complete, control,
//              retire and status signals
//
// Every output is decoded from registered state only. No input reaches an
// output in the same cycle, so completions and allocations become visible
// one cycle after they are accepted.
// ---------------------------------------------------------------------------
module rob
  import rob_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int RETIRE_COUNT = 4,
  parameter int COUNT_WIDTH  = $clog2(RETIRE_COUNT),
  parameter int TAG_WIDTH    = $clog2(DEPTH)
) (
  input  logic  clock,
  input  logic  reset_n,
  rob_if.slave  bus
);

  localparam int CW = TAG_WIDTH + 1;   // width of count-like quantities

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  rob_entry_t           r_entry [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_done;
  logic [TAG_WIDTH-1:0] r_head;
  logic [TAG_WIDTH-1:0] r_tail;
  logic [CW-1:0]        r_count;

  // -------------------------------------------------------------------------
  // Retire window
  // -------------------------------------------------------------------------
  logic [TAG_WIDTH-1:0]    w_slot_idx [RETIRE_COUNT];
  logic [RETIRE_COUNT-1:0] w_slot_valid;
  logic [CW-1:0]           w_prefix_len;

  // NOTE: every variable that always_comb writes gets a default before any
  // conditional logic. Otherwise a path that leaves it unassigned infers a latch.
  always_comb begin : window_decode
    logic w_run;
    w_run        = 1'b1;
    w_prefix_len = '0;
    w_slot_valid = '0;
    for (int i = 0; i < RETIRE_COUNT; i++) begin
      // The index wraps modulo DEPTH because it has the same width as head.
      w_slot_idx[i]   = r_head + TAG_WIDTH'(i);
      // The running AND stops the window at the first entry that is
      // not yet complete. The valid slots therefore always form a prefix.
      w_run           = w_run & r_valid[w_slot_idx[i]] & r_done[w_slot_idx[i]];
      w_slot_valid[i] = w_run;
      w_prefix_len    = w_prefix_len + CW'(w_run);
    end
  end

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic          w_alloc_ready;
  logic          w_alloc_fire;
  logic          w_consume_fire;
  logic [CW-1:0] w_req_len;
  logic [CW-1:0] w_pops;

  always_comb begin : handshake_decode
    // alloc_ready depends only on the registered count. A retire in the
    // same cycle does not free space for an allocation in that cycle.
    w_alloc_ready  = (r_count < CW'(DEPTH));
    w_alloc_fire   = bus.alloc_req & w_alloc_ready & ~bus.flush;
    w_consume_fire = bus.consume & ~bus.flush & w_slot_valid[0];
    w_req_len      = CW'(bus.consume_count) + CW'(1);
    w_pops         = '0;
    if (w_consume_fire) begin
      w_pops = (w_req_len < w_prefix_len) ? w_req_len : w_prefix_len;
    end
  end

  // -------------------------------------------------------------------------
  // State update
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // therefore sample pre-edge values, whatever the statement order. Statement
  // order matters only when several writes hit the same register: the last
  // write wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
      // NOTE: the payload array is reset on purpose so that slot_data reads
      // as zero after reset. An array that does not need this should be left
      // unreset so that it can map onto RAM.
      for (int j = 0; j < DEPTH; j++) begin
        r_entry[j] <= '0;
      end
    end else if (bus.flush) begin
      // Flush drops every in-flight entry. The stale payload is unreachable
      // because each valid bit is cleared, and a new allocation rewrites it.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      // Completions are accepted only for entries that were allocated before
      // this cycle. Port 1 is written last, so it wins when both ports hit
      // the same tag.
      for (int p = 0; p < 2; p++) begin
        if (bus.cpl_valid[p] && r_valid[bus.cpl_tag[p]]) begin
          r_entry[bus.cpl_tag[p]].result_lo <= bus.cpl_result_lo[p];
          r_entry[bus.cpl_tag[p]].result_hi <= bus.cpl_result_hi[p];
          r_done[bus.cpl_tag[p]]            <= 1'b1;
        end
      end

      // Retire comes after complete so that a retiring entry is left cleared.
      for (int k = 0; k < RETIRE_COUNT; k++) begin
        if (CW'(k) < w_pops) begin
          r_valid[w_slot_idx[k]] <= 1'b0;
          r_done[w_slot_idx[k]]  <= 1'b0;
        end
      end

      // The tail slot is free whenever an allocation fires, because a full
      // buffer blocks allocation. It cannot overlap a retiring slot.
      if (w_alloc_fire) begin
        r_entry[r_tail] <= '{dest_reg:       bus.alloc_dest_reg,
                             dest_reg_valid: bus.alloc_dest_reg_valid,
                             result_lo:      32'h0,
                             result_hi:      32'h0};
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + TAG_WIDTH'(1);
      end

      r_head  <= r_head + w_pops[TAG_WIDTH-1:0];
      r_count <= r_count + CW'(w_alloc_fire) - w_pops;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (registered state only)
  // -------------------------------------------------------------------------
  assign bus.alloc_ready = w_alloc_ready;
  assign bus.alloc_tag   = r_tail;
  assign bus.slot_valid  = w_slot_valid;
  assign bus.empty       = (r_count == '0);
  assign bus.occupancy   = r_count;

  always_comb begin : slot_mux
    for (int i = 0; i < RETIRE_COUNT; i++) begin
      bus.slot_data[i] = r_entry[w_slot_idx[i]];
    end
  end

endmodule

// File: tb/tb_rob.sv
// ---------------------------------------------------------------------------
// tb_rob - directed self-checking bench for rob (DEPTH=16, RETIRE_COUNT=4).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, after the registered state has settled.
// ---------------------------------------------------------------------------
module tb_rob;
  import rob_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rob_if bus ();

  rob dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rob_entry_t ent(input logic [4:0] d, input logic v,
                                     input logic [31:0] lo, input logic [31:0] hi);
    rob_entry_t e;
    e.dest_reg       = d;
    e.dest_reg_valid = v;
    e.result_lo      = lo;
    e.result_hi      = hi;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cpl();
    bus.cpl_valid = 2'b00;
    for (int p = 0; p < 2; p++) begin
      bus.cpl_tag[p]       = '0;
      bus.cpl_result_lo[p] = '0;
      bus.cpl_result_hi[p] = '0;
    end
  endtask

  task automatic clear_inputs();
    bus.alloc_req            = 1'b0;
    bus.alloc_dest_reg       = '0;
    bus.alloc_dest_reg_valid = 1'b0;
    bus.flush                = 1'b0;
    bus.consume              = 1'b0;
    bus.consume_count        = '0;
    clear_cpl();
  endtask

  task automatic set_cpl(input int p, input logic [3:0] tag,
                         input logic [31:0] lo, input logic [31:0] hi);
    bus.cpl_valid[p]     = 1'b1;
    bus.cpl_tag[p]       = tag;
    bus.cpl_result_lo[p] = lo;
    bus.cpl_result_hi[p] = hi;
  endtask

  task automatic do_alloc(input logic [4:0] d, input logic v);
    bus.alloc_req            = 1'b1;
    bus.alloc_dest_reg       = d;
    bus.alloc_dest_reg_valid = v;
    tick();
    bus.alloc_req            = 1'b0;
  endtask

  task automatic do_consume(input logic [1:0] cnt);
    bus.consume       = 1'b1;
    bus.consume_count = cnt;
    tick();
    bus.consume       = 1'b0;
    bus.consume_count = '0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    #1 rst_n = 1'b0;
    #2;
    // ---------------- reset state ----------------
    check("rst_ready", 128'(bus.alloc_ready), 128'(1));
    check("rst_tag",   128'(bus.alloc_tag),   128'(0));
    check("rst_empty", 128'(bus.empty),       128'(1));
    check("rst_occ",   128'(bus.occupancy),   128'(0));
    check("rst_slotv", 128'(bus.slot_valid),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- in-order alloc, complete, retire 4 ----------------
    do_alloc(5'd1, 1'b1);
    check("a1_occ",   128'(bus.occupancy),  128'(1));
    check("a1_empty", 128'(bus.empty),      128'(0));
    check("a1_tag",   128'(bus.alloc_tag),  128'(1));
    check("a1_slotv", 128'(bus.slot_valid), 128'(0));
    do_alloc(5'd2, 1'b1);
    do_alloc(5'd3, 1'b1);
    do_alloc(5'd4, 1'b0);
    check("a4_occ",   128'(bus.occupancy),  128'(4));
    set_cpl(0, 4'd0, 32'h100, 32'h200);
    set_cpl(1, 4'd1, 32'h101, 32'h201);
    tick();
    clear_cpl();
    set_cpl(0, 4'd2, 32'h102, 32'h202);
    set_cpl(1, 4'd3, 32'h103, 32'h203);
    tick();
    clear_cpl();
    check("c4_slotv", 128'(bus.slot_valid),   128'(4'b1111));
    check("c4_s0",    128'(bus.slot_data[0]), 128'(ent(5'd1, 1'b1, 32'h100, 32'h200)));
    check("c4_s3",    128'(bus.slot_data[3]), 128'(ent(5'd4, 1'b0, 32'h103, 32'h203)));
    do_consume(2'd3);
    check("r4_empty", 128'(bus.empty),        128'(1));
    check("r4_occ",   128'(bus.occupancy),    128'(0));
    check("r4_slotv", 128'(bus.slot_valid),   128'(0));
    check("r4_tag",   128'(bus.alloc_tag),    128'(4));

    // ---------------- out-of-order completion ----------------
    do_flush();
    check("fl_tag",   128'(bus.alloc_tag), 128'(0));
    check("fl_empty", 128'(bus.empty),     128'(1));
    for (int i = 0; i < 4; i++) do_alloc(5'(5 + i), 1'b1);
    set_cpl(0, 4'd2, 32'h22, 32'h0); tick(); clear_cpl();
    check("ooo_t2",   128'(bus.slot_valid), 128'(4'b0000));
    set_cpl(0, 4'd0, 32'h20, 32'h0); tick(); clear_cpl();
    check("ooo_t0",   128'(bus.slot_valid), 128'(4'b0001));
    set_cpl(1, 4'd1, 32'h21, 32'h0); tick(); clear_cpl();
    check("ooo_t1",   128'(bus.slot_valid), 128'(4'b0111));
    do_consume(2'd2);
    check("ooo_occ",  128'(bus.occupancy),    128'(1));
    check("ooo_slotv",128'(bus.slot_valid),   128'(4'b0000));
    check("ooo_head", 128'(bus.slot_data[0]), 128'(ent(5'd8, 1'b1, 32'h0, 32'h0)));
    do_consume(2'd0);
    check("ign_occ",  128'(bus.occupancy),    128'(1));
    set_cpl(0, 4'd3, 32'h33, 32'h44); tick(); clear_cpl();
    check("t3_slotv", 128'(bus.slot_valid),   128'(4'b0001));
    do_consume(2'd3);
    check("clamp_empty", 128'(bus.empty),     128'(1));
    check("clamp_tag",   128'(bus.alloc_tag), 128'(4));

    // ---------------- fill to full ----------------
    do_flush();
    for (int i = 0; i < 16; i++) do_alloc(5'(i), 1'b1);
    check("full_ready", 128'(bus.alloc_ready), 128'(0));
    check("full_occ",   128'(bus.occupancy),   128'(16));
    check("full_tag",   128'(bus.alloc_tag),   128'(0));
    do_alloc(5'd31, 1'b1);
    check("full_drop_occ", 128'(bus.occupancy),             128'(16));
    check("full_drop_s0",  128'(bus.slot_data[0].dest_reg), 128'(0));
    set_cpl(0, 4'd0, 32'h50, 32'h51); tick(); clear_cpl();
    check("full_slotv", 128'(bus.slot_valid), 128'(4'b0001));
    bus.alloc_req      = 1'b1;
    bus.alloc_dest_reg = 5'd30;
    do_consume(2'd0);
    bus.alloc_req      = 1'b0;
    check("fullc_occ",   128'(bus.occupancy),             128'(15));
    check("fullc_ready", 128'(bus.alloc_ready),           128'(1));
    check("fullc_tag",   128'(bus.alloc_tag),             128'(0));
    check("fullc_head",  128'(bus.slot_data[0].dest_reg), 128'(1));

    // ---------------- head-window wrap ----------------
    for (int t = 1; t <= 13; t++) begin
      set_cpl(0, 4'(t), 32'h1000 + 32'(t), 32'h0);
      tick();
      clear_cpl();
    end
    do_consume(2'd3);
    do_consume(2'd3);
    do_consume(2'd3);
    do_consume(2'd0);
    check("wrap_occ",   128'(bus.occupancy),  128'(2));
    check("wrap_slotv", 128'(bus.slot_valid), 128'(4'b0000));
    for (int i = 0; i < 4; i++) do_alloc(5'(20 + i), 1'b1);
    check("wrap_occ6",  128'(bus.occupancy),  128'(6));
    set_cpl(0, 4'd14, 32'hE0E, ~32'hE0E);
    set_cpl(1, 4'd15, 32'hE0F, ~32'hE0F);
    tick(); clear_cpl();
    set_cpl(0, 4'd0, 32'hE00, ~32'hE00);
    set_cpl(1, 4'd1, 32'hE01, ~32'hE01);
    tick(); clear_cpl();
    check("wrap_all",  128'(bus.slot_valid),   128'(4'b1111));
    check("wrap_s0",   128'(bus.slot_data[0]), 128'(ent(5'd14, 1'b1, 32'hE0E, ~32'hE0E)));
    check("wrap_s2",   128'(bus.slot_data[2]), 128'(ent(5'd20, 1'b1, 32'hE00, ~32'hE00)));
    check("wrap_s3",   128'(bus.slot_data[3]), 128'(ent(5'd21, 1'b1, 32'hE01, ~32'hE01)));

    // ---------------- port priority and ignored completions ----------------
    do_flush();
    for (int i = 0; i < 6; i++) do_alloc(5'(10 + i), 1'b1);
    set_cpl(0, 4'd0, 32'h10, 32'h0); set_cpl(1, 4'd1, 32'h11, 32'h0); tick(); clear_cpl();
    set_cpl(0, 4'd2, 32'h12, 32'h0); set_cpl(1, 4'd3, 32'h13, 32'h0); tick(); clear_cpl();
    set_cpl(0, 4'd5, 32'hAAAA, 32'h1); set_cpl(1, 4'd5, 32'hBBBB, 32'h2); tick(); clear_cpl();
    set_cpl(0, 4'd4, 32'h14, 32'h0); tick(); clear_cpl();
    do_consume(2'd3);
    check("prio_occ",   128'(bus.occupancy),    128'(2));
    check("prio_slotv", 128'(bus.slot_valid),   128'(4'b0011));
    check("prio_s1",    128'(bus.slot_data[1]), 128'(ent(5'd15, 1'b1, 32'hBBBB, 32'h2)));
    set_cpl(0, 4'd9, 32'hDEAD, 32'hDEAD); tick(); clear_cpl();
    check("inv_occ",    128'(bus.occupancy),    128'(2));
    check("inv_slotv",  128'(bus.slot_valid),   128'(4'b0011));
    for (int i = 0; i < 3; i++) do_alloc(5'(16 + i), 1'b1);
    set_cpl(0, 4'd9, 32'hDEAD, 32'hDEAD);
    do_alloc(5'd19, 1'b1);
    clear_cpl();
    set_cpl(0, 4'd6, 32'h16, 32'h0); set_cpl(1, 4'd7, 32'h17, 32'h0); tick(); clear_cpl();
    set_cpl(1, 4'd8, 32'h18, 32'h0); tick(); clear_cpl();
    check("inv_win",    128'(bus.slot_valid),   128'(4'b1111));
    do_consume(2'd3);
    check("inv_occ2",   128'(bus.occupancy),    128'(2));
    check("inv_slotv2", 128'(bus.slot_valid),   128'(4'b0001));
    check("inv_s1",     128'(bus.slot_data[1]), 128'(ent(5'd19, 1'b1, 32'h0, 32'h0)));

    // ---------------- flush overrides everything ----------------
    bus.flush          = 1'b1;
    bus.alloc_req      = 1'b1;
    bus.alloc_dest_reg = 5'd1;
    bus.consume        = 1'b1;
    set_cpl(0, 4'd9, 32'h99, 32'h99);
    tick();
    clear_inputs();
    check("flo_empty", 128'(bus.empty),      128'(1));
    check("flo_occ",   128'(bus.occupancy),  128'(0));
    check("flo_slotv", 128'(bus.slot_valid), 128'(0));
    check("flo_tag",   128'(bus.alloc_tag),  128'(0));

    // ---------------- asynchronous reset mid-cycle ----------------
    do_alloc(5'd7, 1'b1);
    do_alloc(5'd8, 1'b1);
    set_cpl(0, 4'd0, 32'h77, 32'h78); tick(); clear_cpl();
    check("pre_slotv", 128'(bus.slot_valid), 128'(4'b0001));
    check("pre_occ",   128'(bus.occupancy),  128'(2));
    #3 rst_n = 1'b0;
    #1;
    check("ar_ready", 128'(bus.alloc_ready),  128'(1));
    check("ar_tag",   128'(bus.alloc_tag),    128'(0));
    check("ar_empty", 128'(bus.empty),        128'(1));
    check("ar_occ",   128'(bus.occupancy),    128'(0));
    check("ar_slotv", 128'(bus.slot_valid),   128'(0));
    check("ar_s0",    128'(bus.slot_data[0]), 128'(0));
    rst_n = 1'b1;
    tick();
    check("post_empty", 128'(bus.empty), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
